// File: rtl/cp0_exc.sv
// Coprocessor-0 exception responder: owns SR/Cause/EPC/PRId, takes interrupts,
// syscall/unimplemented traps and eret at M stage, then flushes and drains the pipe.
//
// state | meaning
// RUN   | M-stage events are evaluated and acted on
// FLUSH | one-cycle squash of IF..M, redirect_pc driven
// DRAIN | DRAIN_CYCLES cycles with M-stage inputs ignored
module cp0_exc #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID         = 32'h0000_0001,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [34:0] exce,
  input  logic        valid,
  input  logic [31:0] pc,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] wdata,
  input  logic [5:0]  hw_int,
  output logic [31:0] rdata,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        exl
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [4:0] EXC_INT    = 5'd0;
  localparam logic [4:0] EXC_SYS    = 5'd8;
  localparam logic [4:0] EXC_RI     = 5'd10;

  state_t      state_q, state_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;
  logic [31:0] redir_q;

  logic        op_mtc0, op_eret, op_sys, op_unimpl;
  logic        active, irq;
  logic        take_exc, take_eret, take_mtc0;
  logic [4:0]  exc_code;

  // mfc0 needs no action here (rdata is always live) and INT32 carries only two causes.
  logic        unused_exce;
  assign unused_exce = ^{exce[34], exce[31:3], exce[0]};

  assign op_mtc0   = exce[33];
  assign op_eret   = exce[32];
  assign op_unimpl = exce[2];
  assign op_sys    = exce[1];

  assign active    = (state_q == RUN) & valid;
  assign irq       = sr_ie & ~sr_exl & (|(cause_ip & sr_im));
  assign take_exc  = active & (irq | op_unimpl | op_sys);
  assign take_eret = active & ~take_exc & op_eret;
  assign take_mtc0 = active & ~take_exc & ~op_eret & op_mtc0;

  always_comb begin
    exc_code = EXC_SYS;
    if (irq)            exc_code = EXC_INT;
    else if (op_unimpl) exc_code = EXC_RI;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drain_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      RUN: begin
        if (take_exc | take_eret) state_d = FLUSH;
      end
      FLUSH: begin
        state_d     = DRAIN;
        drain_cnt_d = DRAIN_LOAD;
      end
      DRAIN: begin
        if (drain_cnt_q == 4'd0) state_d = RUN;
        else                     drain_cnt_d = drain_cnt_q - 4'd1;
      end
      default: begin
        state_d     = RUN;
        drain_cnt_d = 4'd0;
      end
    endcase
  end

  // redir_q captures the target at the decision edge so eret returns the pre-edge EPC.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_im     <= 6'd0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_ip  <= 6'd0;
      cause_exc <= 5'd0;
      epc       <= 32'd0;
      redir_q   <= 32'd0;
    end else begin
      cause_ip <= hw_int;
      if (take_exc) begin
        cause_exc <= exc_code;
        redir_q   <= HANDLER_ADDR;
        if (!sr_exl) begin
          epc    <= {pc[31:2], 2'b00};
          sr_exl <= 1'b1;
        end
      end else if (take_eret) begin
        sr_exl  <= 1'b0;
        redir_q <= epc;
      end else if (take_mtc0) begin
        case (cp0_addr)
          5'd12: begin
            sr_im  <= wdata[15:10];
            sr_exl <= wdata[1];
            sr_ie  <= wdata[0];
          end
          5'd14:   epc <= {wdata[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (cp0_addr)
      5'd12:   rdata = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
      5'd13:   rdata = {16'd0, cause_ip, 3'd0, cause_exc, 2'd0};
      5'd14:   rdata = epc;
      5'd15:   rdata = PRID;
      default: rdata = 32'd0;
    endcase
  end

  assign flush       = (state_q == FLUSH);
  assign redirect_pc = flush ? redir_q : 32'd0;
  assign exl         = sr_exl;

endmodule
